// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode range and status-bit positions.
package alu_pkg;

  localparam int OP_W = 4;
  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 4'd0;
  localparam alu_op_t ALU_SLL   = 4'd1;
  localparam alu_op_t ALU_SLT   = 4'd2;
  localparam alu_op_t ALU_XOR   = 4'd3;
  localparam alu_op_t ALU_SRL   = 4'd4;
  localparam alu_op_t ALU_OR    = 4'd5;
  localparam alu_op_t ALU_AND   = 4'd6;
  localparam alu_op_t ALU_EQ    = 4'd7;
  localparam alu_op_t ALU_GE    = 4'd8;
  localparam alu_op_t ALU_PASSB = 4'd9;

  // Codes above this still complete, with a zero result.
  localparam alu_op_t ALU_OP_FIRST = ALU_ADD;
  localparam alu_op_t ALU_OP_LAST  = ALU_PASSB;

  localparam int ST_W     = 3;
  localparam int ST_ZERO  = 0;
  localparam int ST_NEG   = 1;
  localparam int ST_CARRY = 2;

  function automatic logic op_in_range(input alu_op_t op);
    return (op >= ALU_OP_FIRST) && (op <= ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu_core_if.sv
// Request/response bundle between the execute stage (master) and the ALU (slave).
interface alu_core_if #(
  parameter int WIDTH = 32
) ();
  logic                 run;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 c;
  alu_pkg::alu_op_t     op;
  logic [WIDTH-1:0]     y;
  logic [alu_pkg::ST_W-1:0] st;
  logic                 ack;

  modport master (output run, a, b, c, op, input  y, st, ack);
  modport slave  (input  run, a, b, c, op, output y, st, ack);
endinterface

// File: rtl/alu_core.sv
// Multi-function integer ALU: accept in IDLE, compute in BUSY, one-cycle ack,
// then a DONE cycle so back-to-back requests always see a fresh ack edge.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_core_if.slave   bus
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OP_W-1:0]  op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             c_q,     c_d;
  logic [WIDTH-1:0] y_q,     y_d;
  logic [ST_W-1:0]  st_q,    st_d;
  logic             ack_q,   ack_d;

  logic [WIDTH-1:0] res;
  logic             cry;
  logic [SH_W-1:0]  sh;
  logic             lt, eq;

  assign sh = b_q[SH_W-1:0];
  assign lt = c_q ? (a_q < b_q) : ($signed(a_q) < $signed(b_q));
  assign eq = (a_q == b_q);

  always_comb begin
    res = '0;
    cry = 1'b0;
    case (op_q)
      ALU_ADD: begin
        // SUB as a + ~b + 1, so the carry-out is the no-borrow flag.
        if (c_q) {cry, res} = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        else     {cry, res} = {1'b0, a_q} + {1'b0, b_q};
      end
      ALU_SLL:   res = a_q << sh;
      ALU_SLT:   res = {{(WIDTH-1){1'b0}}, lt};
      ALU_XOR:   res = a_q ^ b_q;
      ALU_SRL:   res = c_q ? WIDTH'($signed(a_q) >>> sh) : (a_q >> sh);
      ALU_OR:    res = a_q | b_q;
      ALU_AND:   res = a_q & b_q;
      ALU_EQ:    res = {{(WIDTH-1){1'b0}}, eq ^ c_q};
      ALU_GE:    res = {{(WIDTH-1){1'b0}}, ~lt};
      ALU_PASSB: res = b_q;
      default:   res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    y_d     = y_q;
    st_d    = st_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.c;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        y_d           = res;
        st_d[ST_ZERO] = (res == '0);
        st_d[ST_NEG]  = res[WIDTH-1];
        st_d[ST_CARRY] = cry;
        ack_d         = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      y_q     <= '0;
      st_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      y_q     <= y_d;
      st_q    <= st_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.y   = y_q;
  assign bus.st  = st_q;
  assign bus.ack = ack_q;

endmodule

// File: tb/tb_alu_core.sv
// Randomized + directed bench for alu_core against an arithmetic reference model.
module tb_alu_core;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_core_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the opcode table.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic c, output logic [31:0] y, output logic [2:0] st);
    logic [63:0] wide;
    int          sh;
    logic        cy;
    sh = int'(b % 32);
    cy = 1'b0;
    case (op)
      4'd0: begin
        if (!c) begin wide = 64'(a) + 64'(b); y = wide[31:0]; cy = wide[32]; end
        else    begin y = a - b; cy = (a >= b); end
      end
      4'd1: y = a << sh;
      4'd2: y = c ? 32'(a < b) : 32'($signed(a) < $signed(b));
      4'd3: y = a ^ b;
      4'd4: y = (a >> sh) | ((c && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd5: y = a | b;
      4'd6: y = a & b;
      4'd7: y = c ? 32'(a != b) : 32'(a == b);
      4'd8: y = c ? 32'(a >= b) : 32'($signed(a) >= $signed(b));
      4'd9: y = b;
      default: y = 32'h0;
    endcase
    st = {cy, y[31], y == 32'h0};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.op = op; bus.a = a; bus.b = b; bus.c = c;
  endtask

  // One isolated request; caller starts with the FSM idle.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic c,
                       input logic [31:0] ey, input logic [2:0] est);
    @(negedge clk); drive(op, a, b, c); bus.run = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".ack_early"}, 64'(bus.ack), 64'd0);
    @(negedge clk); bus.run = 1'b0; drive(4'($urandom), $urandom, $urandom, 1'($urandom));
    @(posedge clk); #1;
    chk({tag, ".ack"}, 64'(bus.ack), 64'd1);
    chk({tag, ".y"},   64'(bus.y),   64'(ey));
    chk({tag, ".st"},  64'(bus.st),  64'(est));
    @(posedge clk); #1;
    chk({tag, ".ack_fall"}, 64'(bus.ack), 64'd0);
    chk({tag, ".y_hold"},   64'(bus.y),   64'(ey));
  endtask

  initial begin
    logic [31:0] ey, ra, rb;
    logic [2:0]  est;
    logic [3:0]  rop;
    logic        rc;
    logic [31:0] qa[$], qb[$];
    logic [3:0]  qop[$];
    logic        qc[$];

    bus.run = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 1'b0);

    // reset and idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.y",   64'(bus.y),   64'd0);
    chk("rst.st",  64'(bus.st),  64'd0);
    chk("rst.ack", 64'(bus.ack), 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle.ack", 64'(bus.ack), 64'd0);
    end

    // directed
    do_op("add",    4'd0, 32'd5, 32'd7, 1'b0, 32'd12, 3'b000);
    do_op("sub0",   4'd0, 32'd5, 32'd5, 1'b1, 32'd0,  3'b101);
    do_op("subneg", 4'd0, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 3'b010);
    do_op("addwrap",4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 3'b101);
    do_op("slt",    4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 3'b000);
    do_op("sltu",   4'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 3'b001);
    do_op("eq",     4'd7, 32'h1234, 32'h1234, 1'b0, 32'd1, 3'b000);
    do_op("ne",     4'd7, 32'h1234, 32'h1234, 1'b1, 32'd0, 3'b001);
    do_op("srl",    4'd4, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000, 3'b000);
    do_op("sra",    4'd4, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 3'b010);
    do_op("sll33",  4'd1, 32'd1, 32'd33, 1'b0, 32'd2, 3'b000);
    do_op("ge",     4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 3'b001);
    do_op("geu",    4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 3'b000);
    do_op("passb",  4'd9, 32'd0, 32'h8000_0001, 1'b0, 32'h8000_0001, 3'b010);
    do_op("badop",  4'd13, 32'd9, 32'd9, 1'b0, 32'd0, 3'b001);

    // random single ops
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rc  = 1'($urandom);
      model(rop, ra, rb, rc, ey, est);
      do_op("rnd", rop, ra, rb, rc, ey, est);
    end

    // run held high: accepts every third edge, operands change every cycle
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      rop = 4'($urandom_range(0, 9)); ra = $urandom; rb = $urandom; rc = 1'($urandom);
      drive(rop, ra, rb, rc); bus.run = 1'b1;
      if (cyc % 3 == 0) begin qop.push_back(rop); qa.push_back(ra); qb.push_back(rb); qc.push_back(rc); end
      @(posedge clk); #1;
      if (cyc % 3 == 1) begin
        model(qop[0], qa[0], qb[0], qc[0], ey, est);
        void'(qop.pop_front()); void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
        chk("b2b.ack", 64'(bus.ack), 64'd1);
        chk("b2b.y",   64'(bus.y),   64'(ey));
        chk("b2b.st",  64'(bus.st),  64'(est));
      end else begin
        chk("b2b.ack0", 64'(bus.ack), 64'd0);
      end
    end
    @(negedge clk); bus.run = 1'b0;

    // run pulsed only while busy/done is dropped, not queued
    @(negedge clk); drive(4'd0, 32'd1, 32'd2, 1'b0); bus.run = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.run = 1'b0;
    @(posedge clk); #1;
    chk("noq.ack", 64'(bus.ack), 64'd1);
    chk("noq.y",   64'(bus.y),   64'd3);
    @(negedge clk); drive(4'd9, 32'd0, 32'd77, 1'b0); bus.run = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("noq.idle", 64'(bus.ack), 64'd0);
    end
    chk("noq.yhold", 64'(bus.y), 64'd3);

    // reset during BUSY abandons the op
    @(negedge clk); drive(4'd9, 32'd0, 32'h55, 1'b0); bus.run = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.run = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rstop.ack", 64'(bus.ack), 64'd0);
    chk("rstop.y",   64'(bus.y),   64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rstop.ack2", 64'(bus.ack), 64'd0);
    do_op("post_rst", 4'd6, 32'hF0F0, 32'hFF00, 1'b0, 32'hF000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
